// File: rtl/spi_frame_tx.sv
// MSB-first SPI frame transmitter (mode 0: data changes on falling clock, stable at rising edge).
// Optional macro SPI_TX_CS_GAP_EN adds a GAP state holding chip select high for CS_GAP clocks.
module spi_frame_tx #(
  parameter int WIDTH       = 16,
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             spi_cs,
  output logic             spi_clock,
  output logic             spi_data
);

  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [HW-1:0] HALF_LOAD = HW'(HALF_PERIOD - 1);
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

`ifdef SPI_TX_CS_GAP_EN
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  logic [GW-1:0] gap_count;
`else
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0]    bit_count;
  logic [HW-1:0]    half_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_count  <= '0;
      half_count <= '0;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      spi_cs     <= 1'b1;
      spi_clock  <= 1'b0;
      spi_data   <= 1'b0;
`ifdef SPI_TX_CS_GAP_EN
      gap_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // data_ready is 1 throughout IDLE, so valid alone completes the handshake
          if (data_valid) begin
            shift      <= data_in;
            bit_count  <= BIT_LOAD;
            half_count <= HALF_LOAD;
            state      <= SETUP;
            data_ready <= 1'b0;
            busy       <= 1'b1;
            spi_cs     <= 1'b0;
            spi_data   <= data_in[WIDTH-1];
          end
        end
        SETUP: begin
          if (half_count == '0) begin
            state      <= HIGH;
            half_count <= HALF_LOAD;
            spi_clock  <= 1'b1;
          end else begin
            half_count <= half_count - HALF_ONE;
          end
        end
        HIGH: begin
          if (half_count == '0) begin
            half_count <= HALF_LOAD;
            spi_clock  <= 1'b0;
            if (bit_count == '0) begin
              state <= HOLD;
            end else begin
              // next bit is presented on the falling edge
              state     <= LOW;
              shift     <= shift << 1;
              spi_data  <= shift[WIDTH-2];
              bit_count <= bit_count - BIT_ONE;
            end
          end else begin
            half_count <= half_count - HALF_ONE;
          end
        end
        LOW: begin
          if (half_count == '0) begin
            state      <= HIGH;
            half_count <= HALF_LOAD;
            spi_clock  <= 1'b1;
          end else begin
            half_count <= half_count - HALF_ONE;
          end
        end
        HOLD: begin
          if (half_count == '0) begin
            half_count <= HALF_LOAD;
            spi_cs     <= 1'b1;
            busy       <= 1'b0;
            spi_data   <= 1'b0;
`ifdef SPI_TX_CS_GAP_EN
            state      <= GAP;
            gap_count  <= GAP_LOAD;
`else
            state      <= IDLE;
            data_ready <= 1'b1;
`endif
          end else begin
            half_count <= half_count - HALF_ONE;
          end
        end
`ifdef SPI_TX_CS_GAP_EN
        GAP: begin
          if (gap_count == '0) begin
            state      <= IDLE;
            data_ready <= 1'b1;
          end else begin
            gap_count <= gap_count - GAP_ONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
